// File: rtl/canny_mag_dir_pipe.sv
// Canny gradient magnitude + quantised direction, with per-frame pixel counting and border blanking.
// Latency: exactly 3 cycles from an accepted beat to out_valid, one beat per cycle.
// Backpressure: none; the pipeline never stalls, and beats outside RUN are dropped.
module canny_mag_dir_pipe #(
  parameter int GRAD_W       = 9,
  parameter int OUT_W        = 8,
  parameter int NORM_SHIFT   = 1,
  parameter int MAG_MODE     = 0,
  parameter int STARTADDRESS = 770,
  parameter int ENDADDRESS   = 261758,
  parameter int FRAME_PIXELS = 262144
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startEn,
  input  logic                     in_valid,
  input  logic signed [GRAD_W-1:0] cannyX,
  input  logic signed [GRAD_W-1:0] cannyY,
  output logic [OUT_W-1:0]         normalisedMag,
  output logic [1:0]               direction,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_PIXELS - 1);
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(STARTADDRESS);
  localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(ENDADDRESS);
  localparam int MAX_OUT = (2 ** OUT_W) - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         drain_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;

  // Stage 1 registers
  logic               s1_vld_q;
  logic [GRAD_W-1:0]  ax_q, ay_q;
  logic               sx_q, sy_q, win1_q;
  logic [GRAD_W-1:0]  ax_d, ay_d;
  logic               win_d;

  // Stage 2 registers
  logic               s2_vld_q;
  logic [GRAD_W:0]    raw_q;
  logic [1:0]         dir2_q;
  logic               win2_q;
  logic [GRAD_W:0]    raw_d;
  logic [1:0]         dir_d;

  // Stage 3 (output) registers
  logic               out_vld_q;
  logic [OUT_W-1:0]   mag_q;
  logic [1:0]         dir_q;
  logic [OUT_W-1:0]   mag_d;
  logic [1:0]         dir3_d;

  assign accept = (state_q == RUN) && in_valid;

  // Frame control: start, pixel index, three-cycle drain, registered busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startEn) begin
            state_q <= RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          // done is raised so that it is visible in the final drain cycle
          if (drain_q == 2'd1) done_q <= 1'b1;
          if (drain_q == 2'd2) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Absolute values and border window test for the incoming beat
  always_comb begin
    ax_d  = cannyX[GRAD_W-1] ? (GRAD_W'(0) - $unsigned(cannyX)) : $unsigned(cannyX);
    ay_d  = cannyY[GRAD_W-1] ? (GRAD_W'(0) - $unsigned(cannyY)) : $unsigned(cannyY);
    win_d = (idx_q >= START_IDX) && (idx_q <= END_IDX);
  end

  // Stage 1: capture magnitudes, signs and window flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      win1_q   <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        ax_q   <= ax_d;
        ay_q   <= ay_d;
        sx_q   <= cannyX[GRAD_W-1];
        sy_q   <= cannyY[GRAD_W-1];
        win1_q <= win_d;
      end
    end
  end

  // Raw magnitude and direction sector from the stage-1 values
  always_comb begin
    logic [GRAD_W-1:0] mx, mn;
    logic [GRAD_W+1:0] tri_mn;
    logic [GRAD_W+3:0] axe, aye, ax12, ay12, ax5, ay5;
    mx     = (ax_q >= ay_q) ? ax_q : ay_q;
    mn     = (ax_q >= ay_q) ? ay_q : ax_q;
    tri_mn = {2'b00, mn} + {1'b0, mn, 1'b0};
    if (MAG_MODE == 1) raw_d = {1'b0, mx} + (GRAD_W+1)'(tri_mn >> 3);
    else               raw_d = {1'b0, ax_q} + {1'b0, ay_q};
    axe  = (GRAD_W+4)'(ax_q);
    aye  = (GRAD_W+4)'(ay_q);
    ax12 = (axe << 3) + (axe << 2);
    ay12 = (aye << 3) + (aye << 2);
    ax5  = (axe << 2) + axe;
    ay5  = (aye << 2) + aye;
    // tan(22.5 deg) ~ 5/12 splits the near-horizontal and near-vertical sectors
    if ((ax_q == '0) && (ay_q == '0)) dir_d = 2'd0;
    else if (ay12 <= ax5)             dir_d = 2'd0;
    else if (ax12 <= ay5)             dir_d = 2'd2;
    else if (sx_q == sy_q)            dir_d = 2'd1;
    else                              dir_d = 2'd3;
  end

  // Stage 2: register raw magnitude and direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      raw_q    <= '0;
      dir2_q   <= '0;
      win2_q   <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        raw_q  <= raw_d;
        dir2_q <= dir_d;
        win2_q <= win1_q;
      end
    end
  end

  // Normalise, saturate and blank border pixels
  always_comb begin
    logic [GRAD_W:0] n;
    n = raw_q >> NORM_SHIFT;
    if (int'(n) > MAX_OUT) mag_d = {OUT_W{1'b1}};
    else                   mag_d = OUT_W'(n);
    dir3_d = dir2_q;
    if (!win2_q) begin
      mag_d  = '0;
      dir3_d = 2'd0;
    end
  end

  // Stage 3: output registers hold their value between beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      mag_q     <= '0;
      dir_q     <= '0;
    end else begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        mag_q <= mag_d;
        dir_q <= dir3_d;
      end
    end
  end

  assign normalisedMag = mag_q;
  assign direction     = dir_q;
  assign out_valid     = out_vld_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_canny_mag_dir_pipe.sv
// Bench for canny_mag_dir_pipe: two instances (L1 and alpha-max-beta-min) on shared stimulus,
// a small frame so a full frame fits in the run, a scoreboard fed by a plain-arithmetic model,
// a vector table for known magnitudes/directions and directed window-boundary sequences.
module tb_canny_mag_dir_pipe;

  localparam int FRAME   = 4096;
  localparam int START_A = 770;
  localparam int END_A   = 3838;

  logic              clk = 1'b0;
  logic              reset;
  logic              startEn;
  logic              in_valid;
  logic signed [8:0] cx, cy;

  logic [7:0] m0_mag, m1_mag;
  logic [1:0] m0_dir, m1_dir;
  logic       m0_ov, m1_ov, m0_busy, m1_busy, m0_done, m1_done;

  canny_mag_dir_pipe #(
    .GRAD_W(9), .OUT_W(8), .NORM_SHIFT(1), .MAG_MODE(0),
    .STARTADDRESS(START_A), .ENDADDRESS(END_A), .FRAME_PIXELS(FRAME)
  ) u_m0 (
    .clk(clk), .reset(reset), .startEn(startEn), .in_valid(in_valid),
    .cannyX(cx), .cannyY(cy), .normalisedMag(m0_mag), .direction(m0_dir),
    .out_valid(m0_ov), .busy(m0_busy), .done(m0_done)
  );

  canny_mag_dir_pipe #(
    .GRAD_W(9), .OUT_W(8), .NORM_SHIFT(1), .MAG_MODE(1),
    .STARTADDRESS(START_A), .ENDADDRESS(END_A), .FRAME_PIXELS(FRAME)
  ) u_m1 (
    .clk(clk), .reset(reset), .startEn(startEn), .in_valid(in_valid),
    .cannyX(cx), .cannyY(cy), .normalisedMag(m1_mag), .direction(m1_dir),
    .out_valid(m1_ov), .busy(m1_busy), .done(m1_done)
  );

  always #5 clk = ~clk;

  typedef struct { int mag0; int dir0; int mag1; int dir1; int cyc; } exp_t;
  typedef struct { int x; int y; int mag0; int dir; int mag1; } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   idx = 0;
  bit   running = 1'b0;
  bit   mon_en = 1'b0;
  int   last_cyc = 0;
  int   ov_cnt = 0;
  int   done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = -1, done_cyc1 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitude and direction straight from the arithmetic definition
  function automatic void model(input int x, input int y, input bit mode1, input bit inwin,
                                output int mag, output int dir);
    int ax, ay, mx, mn, raw, n;
    ax  = (x < 0) ? -x : x;
    ay  = (y < 0) ? -y : y;
    mx  = (ax > ay) ? ax : ay;
    mn  = (ax > ay) ? ay : ax;
    raw = mode1 ? (mx + (3 * mn) / 8) : (ax + ay);
    n   = raw / 2;
    mag = (n > 255) ? 255 : n;
    if (ax == 0 && ay == 0)     dir = 0;
    else if (12 * ay <= 5 * ax) dir = 0;
    else if (12 * ax <= 5 * ay) dir = 2;
    else if ((x < 0) == (y < 0)) dir = 1;
    else                         dir = 3;
    if (!inwin) begin
      mag = 0;
      dir = 0;
    end
  endfunction

  function automatic int rg();
    return int'($urandom_range(511, 0)) - 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; a beat taken while the frame runs is predicted onto the scoreboard
  task automatic drive_beat(input bit v, input int x, input int y, input bit se);
    exp_t e;
    bit   w;
    in_valid = v;
    cx       = 9'(x);
    cy       = 9'(y);
    startEn  = se;
    if (v && running) begin
      w = (idx >= START_A) && (idx <= END_A);
      model(x, y, 1'b0, w, e.mag0, e.dir0);
      model(x, y, 1'b1, w, e.mag1, e.dir1);
      e.cyc = cyc + 3;
      sbq.push_back(e);
      if (idx == FRAME - 1) begin
        running  = 1'b0;
        last_cyc = cyc;
      end
      idx++;
    end
    tick();
  endtask

  task automatic run_until(input int target);
    while (idx < target) drive_beat($urandom_range(1, 0) == 1, rg(), rg(), 1'b0);
  endtask

  task automatic check_out(input string name, input int mag0, input int dir0,
                           input int mag1, input int dir1);
    chk({name, "_ov"},   int'(m0_ov),  1);
    chk({name, "_mag0"}, int'(m0_mag), mag0);
    chk({name, "_dir0"}, int'(m0_dir), dir0);
    chk({name, "_mag1"}, int'(m1_mag), mag1);
    chk({name, "_dir1"}, int'(m1_dir), dir1);
  endtask

  // Scoreboard: every out_valid must match the next prediction at its predicted cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (m0_ov || m1_ov) begin
        exp_t e;
        ov_cnt++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ov", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_cycle", cyc, e.cyc);
          chk("sb_ov_both", int'({m0_ov, m1_ov}), 3);
          chk("sb_mag0", int'(m0_mag), e.mag0);
          chk("sb_dir0", int'(m0_dir), e.dir0);
          chk("sb_mag1", int'(m1_mag), e.mag1);
          chk("sb_dir1", int'(m1_dir), e.dir1);
        end
      end
      if (m0_done) begin
        done_cnt0++;
        done_cyc0 = cyc;
      end
      if (m1_done) begin
        done_cnt1++;
        done_cyc1 = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cycles=%0d limit=30000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0] = '{255,  255,  255, 1, 175};
    tbl[1] = '{-256, -256, 255, 1, 176};
    tbl[2] = '{40,   0,    20,  0, 20};
    tbl[3] = '{0,    -40,  20,  2, 20};
    tbl[4] = '{30,   -30,  30,  3, 20};
    tbl[5] = '{200,  100,  150, 1, 118};
    tbl[6] = '{0,    0,    0,   0, 0};
    tbl[7] = '{-255, 100,  177, 0, 146};
    tbl[8] = '{50,   -120, 85,  2, 69};
    tbl[9] = '{-100, 100,  100, 3, 68};

    reset = 1'b1; startEn = 1'b0; in_valid = 1'b0; cx = '0; cy = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mag0", int'(m0_mag), 0);
    chk("rst_dir0", int'(m0_dir), 0);
    chk("rst_ov0", int'(m0_ov), 0);
    chk("rst_busy0", int'(m0_busy), 0);
    chk("rst_done0", int'(m0_done), 0);
    chk("rst_ov1", int'(m1_ov), 0);
    reset = 1'b0;
    tick();

    // First frame, interrupted by reset at index 100 with beats in flight
    drive_beat(1'b0, 0, 0, 1'b1);
    chk("start_busy", int'(m0_busy), 1);
    running = 1'b1; idx = 0; mon_en = 1'b1;
    repeat (100) drive_beat(1'b1, rg(), rg(), 1'b0);
    chk("prerst_ov", int'(m0_ov), 1);
    in_valid = 1'b1; cx = 9'(20); cy = 9'(20);
    #3;
    mon_en = 1'b0; running = 1'b0; sbq.delete();
    reset = 1'b1;
    #1;
    chk("midrst_ov0", int'(m0_ov), 0);
    chk("midrst_ov1", int'(m1_ov), 0);
    chk("midrst_busy0", int'(m0_busy), 0);
    chk("midrst_busy1", int'(m1_busy), 0);
    chk("midrst_mag0", int'(m0_mag), 0);
    chk("midrst_dir0", int'(m0_dir), 0);
    tick();
    chk("midrst_ov_hold", int'(m0_ov), 0);
    reset = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;
    // Beats offered in IDLE must be dropped
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b0, 0, 0, 1'b0);
    chk("idle_busy", int'(m0_busy), 0);
    repeat (3) drive_beat(1'b0, 0, 0, 1'b0);

    // Full frame from index 0
    ov_cnt = 0; done_cnt0 = 0; done_cnt1 = 0;
    drive_beat(1'b0, 0, 0, 1'b1);
    running = 1'b1; idx = 0;
    run_until(769);
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b0, 0, 0, 1'b0);
    check_out("idx769", 0, 0, 0, 0);
    drive_beat(1'b0, 0, 0, 1'b0);
    check_out("idx770", 100, 1, 68, 1);

    for (int i = 0; i < 10; i++) begin
      drive_beat(1'b1, tbl[i].x, tbl[i].y, 1'b0);
      drive_beat(1'b0, 0, 0, 1'b0);
      drive_beat(1'b0, 0, 0, 1'b0);
      check_out($sformatf("tbl%0d", i), tbl[i].mag0, tbl[i].dir, tbl[i].mag1, tbl[i].dir);
    end

    run_until(2000);
    drive_beat(1'b1, rg(), rg(), 1'b1);
    chk("run_start_ignored_busy", int'(m0_busy), 1);
    run_until(END_A);
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b1, 100, 100, 1'b0);
    drive_beat(1'b0, 0, 0, 1'b0);
    check_out("idx_end", 100, 1, 68, 1);
    drive_beat(1'b0, 0, 0, 1'b0);
    check_out("idx_end_p1", 0, 0, 0, 0);

    run_until(FRAME - 1);
    drive_beat(1'b1, rg(), rg(), 1'b0);
    // startEn and beats during DRAIN/IDLE must have no effect
    drive_beat(1'b1, rg(), rg(), 1'b1);
    repeat (6) drive_beat(1'b1, rg(), rg(), 1'b0);
    in_valid = 1'b0; startEn = 1'b0;
    tick();
    tick();

    chk("frame_ov_count", ov_cnt, FRAME);
    chk("sb_empty", sbq.size(), 0);
    chk("done_count0", done_cnt0, 1);
    chk("done_count1", done_cnt1, 1);
    chk("done_cycle0", done_cyc0, last_cyc + 3);
    chk("done_cycle1", done_cyc1, last_cyc + 3);
    chk("end_busy0", int'(m0_busy), 0);
    chk("end_busy1", int'(m1_busy), 0);
    chk("end_ov0", int'(m0_ov), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
